// File: rtl/rob_commit_buffer.sv
// Reorder buffer between rename/regfile and the ALU: tracks operand readiness,
// issues the oldest ready entry each cycle and commits results in program order.
module rob_commit_buffer #(
  parameter int Depth     = 16,
  parameter int PtrWidth  = 4,
  parameter int DataWidth = 32,
  parameter int PcWidth   = 32,
  parameter int OpWidth   = 7,
  parameter int RdWidth   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_empty_from_rf,
  input  logic [PcWidth-1:0]   pc_from_rf,
  input  logic [OpWidth-1:0]   op_from_rf,
  input  logic [DataWidth-1:0] imm_from_rf,
  input  logic [DataWidth-1:0] v1_from_rf,
  input  logic [DataWidth-1:0] v2_from_rf,
  input  logic [PcWidth-1:0]   q1_from_rf,
  input  logic [PcWidth-1:0]   q2_from_rf,
  input  logic [RdWidth-1:0]   rd_from_decoder,
  output logic                 is_full_to_decoder,
  output logic                 is_valid_to_alu,
  output logic [OpWidth-1:0]   op_to_alu,
  output logic [PcWidth-1:0]   pc_to_alu,
  output logic [DataWidth-1:0] v1_to_alu,
  output logic [DataWidth-1:0] v2_to_alu,
  output logic [DataWidth-1:0] imm_to_alu,
  input  logic                 is_valid_from_alu,
  input  logic [PcWidth-1:0]   pc_from_alu,
  input  logic [DataWidth-1:0] data_from_alu,
  input  logic                 is_exception_from_alu,
  input  logic [PcWidth-1:0]   new_pc_from_alu,
  output logic                 is_finish_to_rf,
  output logic                 is_exception_to_rf,
  output logic [PcWidth-1:0]   pc_to_rf,
  output logic [RdWidth-1:0]   rd_to_rf,
  output logic [DataWidth-1:0] data_to_rf,
  output logic [PcWidth-1:0]   new_pc_to_fetch
);

  localparam logic [PtrWidth:0] FullCount = (PtrWidth+1)'(Depth);

  logic                 ent_valid  [Depth];
  logic                 ent_issued [Depth];
  logic                 ent_done   [Depth];
  logic                 ent_exc    [Depth];
  logic [OpWidth-1:0]   ent_op     [Depth];
  logic [PcWidth-1:0]   ent_pc     [Depth];
  logic [DataWidth-1:0] ent_imm    [Depth];
  logic [DataWidth-1:0] ent_v1     [Depth];
  logic [PcWidth-1:0]   ent_q1     [Depth];
  logic [DataWidth-1:0] ent_v2     [Depth];
  logic [PcWidth-1:0]   ent_q2     [Depth];
  logic [RdWidth-1:0]   ent_rd     [Depth];
  logic [DataWidth-1:0] ent_data   [Depth];
  logic [PcWidth-1:0]   ent_new_pc [Depth];

  logic [PtrWidth-1:0]  head, tail;
  logic [PtrWidth:0]    count;

  logic                 alloc_ok, commit_ok, commit_exc;
  logic                 issue_found;
  logic [PtrWidth-1:0]  issue_idx, scan;
  logic [DataWidth-1:0] alloc_v1, alloc_v2;
  logic [PcWidth-1:0]   alloc_q1, alloc_q2;

  assign is_full_to_decoder = (count == FullCount);
  assign alloc_ok           = !is_empty_from_rf && (count != FullCount);
  assign commit_ok          = ent_valid[head] && ent_done[head];
  assign commit_exc         = commit_ok && ent_exc[head];

  // A tag is satisfied by a same-cycle broadcast first, then by a finished entry.
  function automatic logic [DataWidth+PcWidth-1:0] resolve(
    input logic [PcWidth-1:0]   tag,
    input logic [DataWidth-1:0] value
  );
    logic [DataWidth-1:0] v;
    logic [PcWidth-1:0]   q;
    v = value;
    q = tag;
    if (tag != '0) begin
      if (is_valid_from_alu && (pc_from_alu == tag)) begin
        v = data_from_alu;
        q = '0;
      end else begin
        for (int i = 0; i < Depth; i++) begin
          if (ent_valid[i] && ent_done[i] && (ent_pc[i] == tag)) begin
            v = ent_data[i];
            q = '0;
          end
        end
      end
    end
    return {v, q};
  endfunction

  always_comb begin
    {alloc_v1, alloc_q1} = resolve(q1_from_rf, v1_from_rf);
    {alloc_v2, alloc_q2} = resolve(q2_from_rf, v2_from_rf);
  end

  // Age order runs from head, so the first hit is the oldest ready entry.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = head;
    scan        = '0;
    for (int i = 0; i < Depth; i++) begin
      scan = head + PtrWidth'(i);
      if (!issue_found && ent_valid[scan] && !ent_issued[scan] &&
          (ent_q1[scan] == '0) && (ent_q2[scan] == '0)) begin
        issue_found = 1'b1;
        issue_idx   = scan;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_issued[i] <= 1'b0;
        ent_done[i]   <= 1'b0;
        ent_exc[i]    <= 1'b0;
        ent_op[i]     <= '0;
        ent_pc[i]     <= '0;
        ent_imm[i]    <= '0;
        ent_v1[i]     <= '0;
        ent_q1[i]     <= '0;
        ent_v2[i]     <= '0;
        ent_q2[i]     <= '0;
        ent_rd[i]     <= '0;
        ent_data[i]   <= '0;
        ent_new_pc[i] <= '0;
      end
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      is_valid_to_alu    <= 1'b0;
      op_to_alu          <= '0;
      pc_to_alu          <= '0;
      v1_to_alu          <= '0;
      v2_to_alu          <= '0;
      imm_to_alu         <= '0;
      is_finish_to_rf    <= 1'b0;
      is_exception_to_rf <= 1'b0;
      pc_to_rf           <= '0;
      rd_to_rf           <= '0;
      data_to_rf         <= '0;
      new_pc_to_fetch    <= '0;
    end else begin
      is_valid_to_alu    <= 1'b0;
      is_finish_to_rf    <= 1'b0;
      is_exception_to_rf <= 1'b0;
      if (commit_exc) begin
        // Redirect: retire the faulting head and drop every younger entry.
        is_finish_to_rf    <= 1'b1;
        is_exception_to_rf <= 1'b1;
        pc_to_rf           <= ent_pc[head];
        rd_to_rf           <= ent_rd[head];
        data_to_rf         <= ent_data[head];
        new_pc_to_fetch    <= ent_new_pc[head];
        for (int i = 0; i < Depth; i++) begin
          ent_valid[i]  <= 1'b0;
          ent_issued[i] <= 1'b0;
          ent_done[i]   <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (is_valid_from_alu) begin
          for (int i = 0; i < Depth; i++) begin
            if (ent_valid[i]) begin
              if ((ent_q1[i] != '0) && (ent_q1[i] == pc_from_alu)) begin
                ent_v1[i] <= data_from_alu;
                ent_q1[i] <= '0;
              end
              if ((ent_q2[i] != '0) && (ent_q2[i] == pc_from_alu)) begin
                ent_v2[i] <= data_from_alu;
                ent_q2[i] <= '0;
              end
              if (ent_pc[i] == pc_from_alu) begin
                ent_done[i]   <= 1'b1;
                ent_data[i]   <= data_from_alu;
                ent_exc[i]    <= is_exception_from_alu;
                ent_new_pc[i] <= new_pc_from_alu;
              end
            end
          end
        end
        if (issue_found) begin
          is_valid_to_alu       <= 1'b1;
          op_to_alu             <= ent_op[issue_idx];
          pc_to_alu             <= ent_pc[issue_idx];
          v1_to_alu             <= ent_v1[issue_idx];
          v2_to_alu             <= ent_v2[issue_idx];
          imm_to_alu            <= ent_imm[issue_idx];
          ent_issued[issue_idx] <= 1'b1;
        end
        if (commit_ok) begin
          is_finish_to_rf <= 1'b1;
          pc_to_rf        <= ent_pc[head];
          rd_to_rf        <= ent_rd[head];
          data_to_rf      <= ent_data[head];
          ent_valid[head] <= 1'b0;
          head            <= head + 1'b1;
        end
        if (alloc_ok) begin
          ent_valid[tail]  <= 1'b1;
          ent_issued[tail] <= 1'b0;
          ent_done[tail]   <= 1'b0;
          ent_exc[tail]    <= 1'b0;
          ent_op[tail]     <= op_from_rf;
          ent_pc[tail]     <= pc_from_rf;
          ent_imm[tail]    <= imm_from_rf;
          ent_v1[tail]     <= alloc_v1;
          ent_q1[tail]     <= alloc_q1;
          ent_v2[tail]     <= alloc_v2;
          ent_q2[tail]     <= alloc_q2;
          ent_rd[tail]     <= rd_from_decoder;
          tail             <= tail + 1'b1;
        end
        case ({alloc_ok, commit_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_buffer.sv
// Scoreboard bench for rob_commit_buffer: directed stimulus pushes expected
// issues/commits, a negedge monitor pops and compares whatever the DUT emits.
module tb_rob_commit_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_empty_from_rf = 1'b1;
  logic [31:0] pc_from_rf = '0;
  logic [6:0]  op_from_rf = '0;
  logic [31:0] imm_from_rf = '0;
  logic [31:0] v1_from_rf = '0;
  logic [31:0] v2_from_rf = '0;
  logic [31:0] q1_from_rf = '0;
  logic [31:0] q2_from_rf = '0;
  logic [4:0]  rd_from_decoder = '0;
  logic        is_full_to_decoder;
  logic        is_valid_to_alu;
  logic [6:0]  op_to_alu;
  logic [31:0] pc_to_alu, v1_to_alu, v2_to_alu, imm_to_alu;
  logic        is_valid_from_alu = 1'b0;
  logic [31:0] pc_from_alu = '0;
  logic [31:0] data_from_alu = '0;
  logic        is_exception_from_alu = 1'b0;
  logic [31:0] new_pc_from_alu = '0;
  logic        is_finish_to_rf, is_exception_to_rf;
  logic [31:0] pc_to_rf, data_to_rf, new_pc_to_fetch;
  logic [4:0]  rd_to_rf;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [31:0] imm;
    logic [31:0] v1;
    logic [31:0] v2;
  } issue_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [31:0] new_pc;
  } commit_t;

  issue_t  issue_q[$];
  commit_t commit_q[$];
  int      checks = 0;
  int      failures = 0;

  rob_commit_buffer dut (
    .clk(clk), .rst(rst),
    .is_empty_from_rf(is_empty_from_rf), .pc_from_rf(pc_from_rf),
    .op_from_rf(op_from_rf), .imm_from_rf(imm_from_rf),
    .v1_from_rf(v1_from_rf), .v2_from_rf(v2_from_rf),
    .q1_from_rf(q1_from_rf), .q2_from_rf(q2_from_rf),
    .rd_from_decoder(rd_from_decoder), .is_full_to_decoder(is_full_to_decoder),
    .is_valid_to_alu(is_valid_to_alu), .op_to_alu(op_to_alu),
    .pc_to_alu(pc_to_alu), .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu),
    .imm_to_alu(imm_to_alu), .is_valid_from_alu(is_valid_from_alu),
    .pc_from_alu(pc_from_alu), .data_from_alu(data_from_alu),
    .is_exception_from_alu(is_exception_from_alu), .new_pc_from_alu(new_pc_from_alu),
    .is_finish_to_rf(is_finish_to_rf), .is_exception_to_rf(is_exception_to_rf),
    .pc_to_rf(pc_to_rf), .rd_to_rf(rd_to_rf), .data_to_rf(data_to_rf),
    .new_pc_to_fetch(new_pc_to_fetch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [6:0] op, input logic [31:0] imm,
                               input logic [31:0] v1, input logic [31:0] q1,
                               input logic [31:0] v2, input logic [31:0] q2, input logic [4:0] rd);
    is_empty_from_rf = 1'b0;
    pc_from_rf       = pc;
    op_from_rf       = op;
    imm_from_rf      = imm;
    v1_from_rf       = v1;
    q1_from_rf       = q1;
    v2_from_rf       = v2;
    q2_from_rf       = q2;
    rd_from_decoder  = rd;
  endtask

  task automatic broadcast(input logic [31:0] pc, input logic [31:0] data,
                           input logic exc, input logic [31:0] new_pc);
    is_valid_from_alu     = 1'b1;
    pc_from_alu           = pc;
    data_from_alu         = data;
    is_exception_from_alu = exc;
    new_pc_from_alu       = new_pc;
  endtask

  task automatic expectIssue(input logic [31:0] pc, input logic [6:0] op, input logic [31:0] imm,
                             input logic [31:0] v1, input logic [31:0] v2);
    issue_t e;
    e.pc = pc; e.op = op; e.imm = imm; e.v1 = v1; e.v2 = v2;
    issue_q.push_back(e);
  endtask

  task automatic expectCommit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                              input logic exc, input logic [31:0] new_pc);
    commit_t e;
    e.pc = pc; e.rd = rd; e.data = data; e.exc = exc; e.new_pc = new_pc;
    commit_q.push_back(e);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    is_empty_from_rf      = 1'b1;
    is_valid_from_alu     = 1'b0;
    is_exception_from_alu = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    for (int i = 0; i < maxCycles && (issue_q.size() != 0 || commit_q.size() != 0); i++)
      stepCycle();
    checkOutput("drain_issue_pending", 32'(issue_q.size()), 32'd0);
    checkOutput("drain_commit_pending", 32'(commit_q.size()), 32'd0);
    issue_q.delete();
    commit_q.delete();
    repeat (3) stepCycle();
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("reset_full", 32'(is_full_to_decoder), 32'd0);
    checkOutput("reset_valid_alu", 32'(is_valid_to_alu), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue_q.delete();
    commit_q.delete();
  endtask

  // Monitor: every DUT strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (is_valid_to_alu) begin
        if (issue_q.size() == 0) begin
          checkOutput("issue_unexpected_pc", pc_to_alu, 32'hFFFF_FFFF);
        end else begin
          issue_t e;
          e = issue_q.pop_front();
          checkOutput("issue_pc", pc_to_alu, e.pc);
          checkOutput("issue_op", 32'(op_to_alu), 32'(e.op));
          checkOutput("issue_imm", imm_to_alu, e.imm);
          checkOutput("issue_v1", v1_to_alu, e.v1);
          checkOutput("issue_v2", v2_to_alu, e.v2);
        end
      end
      if (is_finish_to_rf || is_exception_to_rf) begin
        if (commit_q.size() == 0) begin
          checkOutput("commit_unexpected_pc", pc_to_rf, 32'hFFFF_FFFF);
        end else begin
          commit_t e;
          e = commit_q.pop_front();
          checkOutput("commit_finish", 32'(is_finish_to_rf), 32'd1);
          checkOutput("commit_pc", pc_to_rf, e.pc);
          checkOutput("commit_rd", 32'(rd_to_rf), 32'(e.rd));
          checkOutput("commit_data", data_to_rf, e.data);
          checkOutput("commit_exc", 32'(is_exception_to_rf), 32'(e.exc));
          if (e.exc)
            checkOutput("commit_new_pc", new_pc_to_fetch, e.new_pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_full", 32'(is_full_to_decoder), 32'd0);
    checkOutput("rst_valid_alu", 32'(is_valid_to_alu), 32'd0);
    checkOutput("rst_finish", 32'(is_finish_to_rf), 32'd0);
    checkOutput("rst_exception", 32'(is_exception_to_rf), 32'd0);
    checkOutput("rst_pc_to_alu", pc_to_alu, 32'd0);
    checkOutput("rst_new_pc", new_pc_to_fetch, 32'd0);
    rst = 1'b0;
    stepCycle();

    // Single independent ADD
    applyStimulus(32'd4, 7'h33, 32'd0, 32'd3, 32'd0, 32'd5, 32'd0, 5'd1);
    expectIssue(32'd4, 7'h33, 32'd0, 32'd3, 32'd5);
    stepCycle();
    stepCycle();
    broadcast(32'd4, 32'd8, 1'b0, 32'd0);
    expectCommit(32'd4, 5'd1, 32'd8, 1'b0, 32'd0);
    stepCycle();
    waitDrain(10);

    // Dependent pair, woken by broadcast, committed in order
    applyStimulus(32'd4, 7'h33, 32'd0, 32'd10, 32'd0, 32'd20, 32'd0, 5'd2);
    expectIssue(32'd4, 7'h33, 32'd0, 32'd10, 32'd20);
    stepCycle();
    applyStimulus(32'd8, 7'h13, 32'h11, 32'd0, 32'd4, 32'd1, 32'd0, 5'd3);
    stepCycle();
    broadcast(32'd4, 32'd30, 1'b0, 32'd0);
    expectCommit(32'd4, 5'd2, 32'd30, 1'b0, 32'd0);
    expectIssue(32'd8, 7'h13, 32'h11, 32'd30, 32'd1);
    stepCycle();
    stepCycle();
    broadcast(32'd8, 32'd31, 1'b0, 32'd0);
    expectCommit(32'd8, 5'd3, 32'd31, 1'b0, 32'd0);
    stepCycle();
    waitDrain(10);

    // Fill to Depth, drop the overflow, then wrap into index 0
    doReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(32'h40 + 32'(4 * i), 7'h33, 32'(i), 32'(i), 32'd0, 32'd0, 32'd0, 5'(i));
      expectIssue(32'h40 + 32'(4 * i), 7'h33, 32'(i), 32'(i), 32'd0);
      stepCycle();
    end
    checkOutput("full_at_15", 32'(is_full_to_decoder), 32'd0);
    applyStimulus(32'h7C, 7'h33, 32'd15, 32'd15, 32'd0, 32'd0, 32'd0, 5'd15);
    expectIssue(32'h7C, 7'h33, 32'd15, 32'd15, 32'd0);
    stepCycle();
    checkOutput("full_at_16", 32'(is_full_to_decoder), 32'd1);
    applyStimulus(32'h200, 7'h33, 32'd0, 32'hEE, 32'd0, 32'd0, 32'd0, 5'd20);
    stepCycle();
    checkOutput("full_after_drop", 32'(is_full_to_decoder), 32'd1);
    broadcast(32'h40, 32'h55, 1'b0, 32'd0);
    expectCommit(32'h40, 5'd0, 32'h55, 1'b0, 32'd0);
    stepCycle();
    stepCycle();
    checkOutput("full_after_commit", 32'(is_full_to_decoder), 32'd0);
    applyStimulus(32'h300, 7'h33, 32'd0, 32'h77, 32'd0, 32'd0, 32'd0, 5'd7);
    expectIssue(32'h300, 7'h33, 32'd0, 32'h77, 32'd0);
    stepCycle();
    checkOutput("full_after_wrap_alloc", 32'(is_full_to_decoder), 32'd1);
    for (int i = 1; i < 16; i++) begin
      broadcast(32'h40 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 32'd0);
      expectCommit(32'h40 + 32'(4 * i), 5'(i), 32'h1000 + 32'(i), 1'b0, 32'd0);
      stepCycle();
    end
    broadcast(32'h300, 32'h99, 1'b0, 32'd0);
    expectCommit(32'h300, 5'd7, 32'h99, 1'b0, 32'd0);
    stepCycle();
    waitDrain(30);

    // Operand forwarded from a same-cycle broadcast
    applyStimulus(32'h500, 7'h33, 32'd0, 32'd0, 32'h20, 32'd2, 32'd0, 5'd4);
    broadcast(32'h20, 32'd7, 1'b0, 32'd0);
    expectIssue(32'h500, 7'h33, 32'd0, 32'd7, 32'd2);
    stepCycle();
    stepCycle();
    @(negedge clk);
    checkOutput("fwd_issue_immediate", 32'(is_valid_to_alu), 32'd1);
    broadcast(32'h500, 32'd9, 1'b0, 32'd0);
    expectCommit(32'h500, 5'd4, 32'd9, 1'b0, 32'd0);
    stepCycle();
    waitDrain(10);

    // Exception at head flushes five younger dependents
    applyStimulus(32'h600, 7'h63, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 5'd5);
    expectIssue(32'h600, 7'h63, 32'd0, 32'd1, 32'd1);
    stepCycle();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(32'h600 + 32'(4 * i), 7'h33, 32'd0, 32'd0, 32'h600, 32'd0, 32'd0, 5'(5 + i));
      stepCycle();
    end
    broadcast(32'h600, 32'hAB, 1'b1, 32'h100);
    expectCommit(32'h600, 5'd5, 32'hAB, 1'b1, 32'h100);
    stepCycle();
    stepCycle();
    waitDrain(10);
    repeat (4) stepCycle();
    applyStimulus(32'h700, 7'h33, 32'd0, 32'd2, 32'd0, 32'd3, 32'd0, 5'd9);
    expectIssue(32'h700, 7'h33, 32'd0, 32'd2, 32'd3);
    stepCycle();
    stepCycle();
    broadcast(32'h700, 32'd5, 1'b0, 32'd0);
    expectCommit(32'h700, 5'd9, 32'd5, 1'b0, 32'd0);
    stepCycle();
    waitDrain(10);

    // Asynchronous reset with three entries in flight
    applyStimulus(32'h800, 7'h33, 32'd0, 32'd4, 32'd0, 32'd4, 32'd0, 5'd10);
    expectIssue(32'h800, 7'h33, 32'd0, 32'd4, 32'd4);
    stepCycle();
    applyStimulus(32'h804, 7'h33, 32'd0, 32'd0, 32'h900, 32'd0, 32'd0, 5'd11);
    stepCycle();
    applyStimulus(32'h808, 7'h33, 32'd0, 32'd0, 32'h900, 32'd0, 32'd0, 5'd12);
    stepCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid_alu", 32'(is_valid_to_alu), 32'd0);
    checkOutput("async_rst_pc_to_alu", pc_to_alu, 32'd0);
    checkOutput("async_rst_v1_to_alu", v1_to_alu, 32'd0);
    checkOutput("async_rst_pc_to_rf", pc_to_rf, 32'd0);
    checkOutput("async_rst_data_to_rf", data_to_rf, 32'd0);
    checkOutput("async_rst_new_pc", new_pc_to_fetch, 32'd0);
    checkOutput("async_rst_full", 32'(is_full_to_decoder), 32'd0);
    checkOutput("async_rst_issue_pending", 32'(issue_q.size()), 32'd0);
    issue_q.delete();
    commit_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    broadcast(32'h900, 32'd1, 1'b0, 32'd0);
    stepCycle();
    repeat (3) stepCycle();
    applyStimulus(32'hA00, 7'h33, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 5'd12);
    expectIssue(32'hA00, 7'h33, 32'd0, 32'd1, 32'd1);
    stepCycle();
    stepCycle();
    broadcast(32'hA00, 32'h42, 1'b0, 32'd0);
    expectCommit(32'hA00, 5'd12, 32'h42, 1'b0, 32'd0);
    stepCycle();
    waitDrain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
